// File: rtl/data_mem_wb.sv
// Wishbone-style data memory slave with programmable wait states.
// Byte-masked word stores, registered word loads, stall while busy.
module data_mem_wb #(
  parameter int DWIDTH      = 32,
  parameter int AWIDTH      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_cyc,
  input  logic              wb_stb,
  input  logic              wb_we,
  input  logic              wb_rd,
  input  logic [31:0]       wb_addr,
  input  logic [DWIDTH-1:0] wb_wdata,
  input  logic [3:0]        wb_sel,
  output logic [DWIDTH-1:0] wb_rdata,
  output logic              wb_ack,
  output logic              wb_stall
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t              state;
  logic [3:0]          cnt;
  logic [AWIDTH-1:0]   idx_q;
  logic [DWIDTH-1:0]   wdata_q;
  logic [3:0]          sel_q;
  logic                we_q;

  logic [DWIDTH-1:0]   ram [2**AWIDTH];

  logic                req;
  logic                enter_ack;
  logic [AWIDTH-1:0]   cur_idx;
  logic [DWIDTH-1:0]   cur_wdata;
  logic [3:0]          cur_sel;
  logic                cur_we;
  logic                unused_addr;

  assign unused_addr = ^{wb_addr[31:AWIDTH+2], wb_addr[1:0]};

  // With zero wait states the access completes on the accept edge,
  // so the live bus fields are used instead of the latched copy.
  always_comb begin
    req       = wb_cyc & wb_stb & (wb_we | wb_rd);
    enter_ack = 1'b0;
    if (rst_n) begin
      enter_ack = (state == S_IDLE && req && WAIT_CYCLES == 0)
               || (state == S_WAIT && wb_cyc && cnt == 4'd1);
    end
    if (state == S_IDLE) begin
      cur_idx   = wb_addr[AWIDTH+1:2];
      cur_wdata = wb_wdata;
      cur_sel   = wb_sel;
      cur_we    = wb_we;
    end else begin
      cur_idx   = idx_q;
      cur_wdata = wdata_q;
      cur_sel   = sel_q;
      cur_we    = we_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idx_q    <= '0;
      wdata_q  <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      wb_ack   <= 1'b0;
      wb_stall <= 1'b0;
      wb_rdata <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req) begin
            idx_q    <= wb_addr[AWIDTH+1:2];
            wdata_q  <= wb_wdata;
            sel_q    <= wb_sel;
            we_q     <= wb_we;
            cnt      <= WAIT_INIT;
            wb_stall <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state  <= S_ACK;
              wb_ack <= 1'b1;
            end else begin
              state  <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!wb_cyc) begin
            state    <= S_IDLE;
            cnt      <= '0;
            wb_stall <= 1'b0;
          end else if (cnt == 4'd1) begin
            state  <= S_ACK;
            cnt    <= '0;
            wb_ack <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_ACK: begin
          state    <= S_IDLE;
          wb_ack   <= 1'b0;
          wb_stall <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          wb_ack   <= 1'b0;
          wb_stall <= 1'b0;
        end
      endcase
      if (enter_ack && !cur_we) begin
        wb_rdata <= ram[cur_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enter_ack && cur_we) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_sel[i]) begin
          ram[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_wb.sv
// Directed testbench for data_mem_wb.
// Three instances cover wait-state settings 0, 1 and 3.
module tb_data_mem_wb;

  logic        clk;
  logic        rst_n;
  logic        cyc;
  logic        stb;
  logic        we;
  logic        rd;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic [31:0] rdata [3];
  logic        ack [3];
  logic        stall [3];

  int vectors;
  int errors;

  data_mem_wb #(.DWIDTH(32), .AWIDTH(10), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .wb_cyc(cyc), .wb_stb(stb),
    .wb_we(we), .wb_rd(rd), .wb_addr(addr), .wb_wdata(wdata),
    .wb_sel(sel), .wb_rdata(rdata[0]), .wb_ack(ack[0]),
    .wb_stall(stall[0])
  );

  data_mem_wb #(.DWIDTH(32), .AWIDTH(10), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .wb_cyc(cyc), .wb_stb(stb),
    .wb_we(we), .wb_rd(rd), .wb_addr(addr), .wb_wdata(wdata),
    .wb_sel(sel), .wb_rdata(rdata[1]), .wb_ack(ack[1]),
    .wb_stall(stall[1])
  );

  data_mem_wb #(.DWIDTH(32), .AWIDTH(10), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst_n(rst_n), .wb_cyc(cyc), .wb_stb(stb),
    .wb_we(we), .wb_rd(rd), .wb_addr(addr), .wb_wdata(wdata),
    .wb_sel(sel), .wb_rdata(rdata[2]), .wb_ack(ack[2]),
    .wb_stall(stall[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request; lat = cycles from accept edge to ack sample.
  task automatic xfer(input int d, input logic pwe, input logic prd,
                      input logic [31:0] pa, input logic [31:0] pwd,
                      input logic [3:0] psel, output int lat,
                      output int stl, output logic [31:0] rdo,
                      output logic busy_after);
    cyc = 1'b1; stb = 1'b1; we = pwe; rd = prd;
    addr = pa; wdata = pwd; sel = psel;
    tick();
    stb = 1'b0;
    lat = 1;
    stl = 0;
    while (!ack[d] && lat < 20) begin
      if (stall[d]) stl++;
      tick();
      lat++;
    end
    if (stall[d]) stl++;
    rdo = rdata[d];
    cyc = 1'b0; we = 1'b0; rd = 1'b0;
    tick();
    busy_after = ack[d] | stall[d];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc = 0; stb = 0; we = 0; rd = 0;
    addr = 0; wdata = 0; sel = 0;
    repeat (2) tick();
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (ack[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_ack[%0d] got %b want 0", d, ack[d]);
      end
      vectors++;
      if (stall[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_stall[%0d] got %b want 0", d, stall[d]);
      end
      vectors++;
      if (rdata[d] !== 32'h0) begin
        errors++;
        $display("FAIL reset_rdata[%0d] got %h want 0", d, rdata[d]);
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_store_load();
    int lat, stl;
    logic [31:0] r;
    logic b;
    xfer(1, 1, 0, 32'h10, 32'hDEADBEEF, 4'hF, lat, stl, r, b);
    vectors++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL st_latency got %0d want 2", lat);
    end
    vectors++;
    if (stl !== 2) begin
      errors++;
      $display("FAIL st_stall_cycles got %0d want 2", stl);
    end
    vectors++;
    if (b !== 1'b0) begin
      errors++;
      $display("FAIL st_ack_width busy after ack got %b want 0", b);
    end
    xfer(1, 0, 1, 32'h10, 32'h0, 4'h0, lat, stl, r, b);
    vectors++;
    if (r !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL ld_data got %h want deadbeef", r);
    end
    vectors++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL ld_latency got %0d want 2", lat);
    end
  endtask

  task automatic test_byte_mask();
    int lat, stl;
    logic [31:0] r;
    logic b;
    xfer(1, 1, 0, 32'h20, 32'h11223344, 4'hF, lat, stl, r, b);
    xfer(1, 1, 0, 32'h20, 32'hAABBCCDD, 4'b0101, lat, stl, r, b);
    xfer(1, 0, 1, 32'h20, 32'h0, 4'h0, lat, stl, r, b);
    vectors++;
    if (r !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL byte_mask got %h want 11bb33dd", r);
    end
    xfer(1, 1, 0, 32'h20, 32'hFFFFFFFF, 4'h0, lat, stl, r, b);
    vectors++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL sel0_ack latency got %0d want 2", lat);
    end
    xfer(1, 0, 1, 32'h20, 32'h0, 4'h0, lat, stl, r, b);
    vectors++;
    if (r !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL sel0_nowrite got %h want 11bb33dd", r);
    end
  endtask

  task automatic test_wrap_priority();
    int lat, stl;
    logic [31:0] r;
    logic b;
    xfer(1, 1, 1, 32'h1000, 32'h12345678, 4'hF, lat, stl, r, b);
    vectors++;
    if (r !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL we_rd_rdata got %h want 11bb33dd", r);
    end
    xfer(1, 0, 1, 32'h0, 32'h0, 4'h0, lat, stl, r, b);
    vectors++;
    if (r !== 32'h12345678) begin
      errors++;
      $display("FAIL wrap_store got %h want 12345678", r);
    end
    xfer(1, 0, 1, 32'h1010, 32'h0, 4'h0, lat, stl, r, b);
    vectors++;
    if (r !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wrap_load got %h want deadbeef", r);
    end
  endtask

  task automatic test_back_to_back();
    int acks;
    cyc = 1; stb = 1; we = 1; rd = 0;
    addr = 32'h30; wdata = 32'hCAFEF00D; sel = 4'hF;
    tick();
    acks = int'(ack[0]);
    vectors++;
    if (ack[0] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ack1 got %b want 1", ack[0]);
    end
    we = 0; rd = 1;
    tick();
    acks += int'(ack[0]);
    vectors++;
    if (stall[0] !== 1'b0 || ack[0] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle stall=%b ack=%b want 0 0",
               stall[0], ack[0]);
    end
    tick();
    acks += int'(ack[0]);
    vectors++;
    if (ack[0] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ack2 got %b want 1", ack[0]);
    end
    vectors++;
    if (rdata[0] !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL b2b_rdata got %h want cafef00d", rdata[0]);
    end
    cyc = 0; stb = 0; rd = 0;
    repeat (3) begin
      tick();
      acks += int'(ack[0]);
    end
    vectors++;
    if (acks !== 2) begin
      errors++;
      $display("FAIL b2b_ack_count got %0d want 2", acks);
    end
  endtask

  task automatic test_abort();
    int lat, stl, late_acks;
    logic [31:0] r;
    logic b;
    xfer(2, 1, 0, 32'h40, 32'h0, 4'hF, lat, stl, r, b);
    vectors++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL w3_latency got %0d want 4", lat);
    end
    cyc = 1; stb = 1; we = 1; rd = 0;
    addr = 32'h40; wdata = 32'h55; sel = 4'hF;
    tick();
    stb = 0;
    tick();
    cyc = 0; we = 0;
    tick();
    vectors++;
    if (stall[2] !== 1'b0 || ack[2] !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle stall=%b ack=%b want 0 0",
               stall[2], ack[2]);
    end
    late_acks = 0;
    repeat (4) begin
      tick();
      late_acks += int'(ack[2]);
    end
    vectors++;
    if (late_acks !== 0) begin
      errors++;
      $display("FAIL abort_noack got %0d acks want 0", late_acks);
    end
    xfer(2, 0, 1, 32'h40, 32'h0, 4'h0, lat, stl, r, b);
    vectors++;
    if (r !== 32'h0) begin
      errors++;
      $display("FAIL abort_nowrite got %h want 0", r);
    end
  endtask

  task automatic test_reset_mid();
    int lat, stl;
    logic [31:0] r;
    logic b;
    xfer(2, 1, 0, 32'h50, 32'hA5A5A5A5, 4'hF, lat, stl, r, b);
    xfer(2, 0, 1, 32'h50, 32'h0, 4'h0, lat, stl, r, b);
    vectors++;
    if (r !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL rst_pre_load got %h want a5a5a5a5", r);
    end
    cyc = 1; stb = 1; we = 1; rd = 0;
    addr = 32'h50; wdata = 32'h5A5A5A5A; sel = 4'hF;
    tick();
    stb = 0;
    tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (ack[2] !== 1'b0 || stall[2] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid ack=%b stall=%b want 0 0",
               ack[2], stall[2]);
    end
    vectors++;
    if (rdata[2] !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_rdata got %h want 0", rdata[2]);
    end
    cyc = 0; we = 0;
    tick();
    rst_n = 1'b1;
    xfer(2, 0, 1, 32'h50, 32'h0, 4'h0, lat, stl, r, b);
    vectors++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL rst_accept latency got %0d want 4", lat);
    end
    vectors++;
    if (r !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL rst_drop_write got %h want a5a5a5a5", r);
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    test_reset();
    test_store_load();
    test_byte_mask();
    test_wrap_priority();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
